// File: rtl/jdrosent_pulse_train_gen.sv
// Pulse-train transmitter: on a synchronized trigger edge, emits count pulses whose high and
// low phases each last width+1 cycles, then strobes done for one cycle.
module jdrosent_pulse_train_gen #(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned WID_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic [CNT_W-1:0] count,
    input  logic [WID_W-1:0] width,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] RemOne   = CNT_W'(1);
    localparam logic [WID_W-1:0] PhaseOne = WID_W'(1);

    state_e           state_q, state_d;
    logic [WID_W-1:0] phase_q, phase_d;
    logic [WID_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             s1_q, s2_q, s3_q;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             trig_edge;

    // s1/s2 resynchronize the asynchronous trigger; s3 delays s2 for edge detection.
    assign trig_edge = s2_q & ~s3_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        width_d = width_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (trig_edge) begin
                    width_d = width;
                    if (count != '0) begin
                        state_d = StHigh;
                        rem_d   = count;
                        phase_d = width;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StHigh: begin
                if (phase_q == '0) begin
                    state_d = StLow;
                    phase_d = width_q;
                    rem_d   = rem_q - RemOne;
                end else begin
                    phase_d = phase_q - PhaseOne;
                end
            end
            StLow: begin
                if (phase_q == '0) begin
                    if (rem_q != '0) begin
                        state_d = StHigh;
                        phase_d = width_q;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    phase_d = phase_q - PhaseOne;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        pulse_d = (state_d == StHigh);
        busy_d  = (state_d == StHigh) || (state_d == StLow);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            width_q <= '0;
            rem_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            width_q <= width_d;
            rem_q   <= rem_d;
            s1_q    <= trig_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = rem_q;
    assign state     = state_q;

endmodule

// File: tb/tb_jdrosent_pulse_train_gen.sv
// Bench for jdrosent_pulse_train_gen: arithmetic burst model compared every cycle, plus
// directed bursts with hand-computed pulse/busy/done counts.
module tb_jdrosent_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trig_in;
    logic [2:0] count;
    logic [1:0] width;
    logic       pulse_out, busy, done;
    logic [2:0] remaining;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    jdrosent_pulse_train_gen #(.CNT_W(3), .WID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig_in   (trig_in),
        .count     (count),
        .width     (width),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a burst is (mc, mw) started at position k=0; position k after start determines
    // every output by plain arithmetic over the phase length L = mw+1.
    bit m1 = 0, m2 = 0, m3 = 0;
    bit active = 0;
    int k = 0, mc = 0, mw = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= 0; m2 <= 0; m3 <= 0;
            active <= 0; k <= 0; mc <= 0; mw <= 0;
        end else begin
            if (!active) begin
                if (m2 && !m3) begin
                    active <= 1; k <= 0; mc <= int'(count); mw <= int'(width);
                end
            end else if (k >= 2 * mc * (mw + 1)) begin
                active <= 0;
            end else begin
                k <= k + 1;
            end
            m1 <= trig_in; m2 <= m1; m3 <= m2;
        end
    end

    always @(negedge clk) begin
        int total, p, e_pulse, e_busy, e_done, e_rem, e_state;
        if (cmp_en) begin
            total = 2 * mc * (mw + 1);
            e_pulse = 0; e_busy = 0; e_done = 0; e_rem = 0; e_state = 0;
            if (active && k < total) begin
                p = k / (mw + 1);
                e_pulse = (p % 2 == 0) ? 1 : 0;
                e_busy  = 1;
                e_rem   = mc - (p + 1) / 2;
                e_state = e_pulse ? 1 : 2;
            end else if (active) begin
                e_done  = 1;
                e_state = 3;
            end
            chk("model_pulse_out", pulse_out, e_pulse);
            chk("model_busy", busy, e_busy);
            chk("model_done", done, e_done);
            chk("model_remaining", remaining, e_rem);
            chk("model_state", state, e_state);
        end
    end

    // Called 2 time units after a rising edge. Raises trig_in and measures the burst until the
    // block is back in IDLE after done.
    task automatic burst(input int c, input int w, input bit hold, input bit disturb,
                         output int nbusy, output int nedge, output int ndone,
                         output int first_high);
        bit prev = 0;
        bit finished = 0;
        nbusy = 0; nedge = 0; ndone = 0; first_high = -1;
        count = 3'(c); width = 2'(w); trig_in = 1'b1;
        for (int i = 0; i < 200 && !finished; i++) begin
            @(posedge clk); #1;
            if (busy) nbusy++;
            if (pulse_out && !prev) nedge++;
            if (pulse_out && first_high < 0) first_high = i;
            prev = pulse_out;
            if (done) ndone++;
            if (ndone > 0 && state == 2'd0) finished = 1;
            #1;
            if (i == 0 && !hold) trig_in = 1'b0;
            if (disturb) begin
                if (i == 10) begin
                    trig_in = 1'b1; count = 3'($urandom); width = 2'($urandom);
                end
                if (i == 20) trig_in = 1'b0;
                if (i == 30) begin
                    count = 3'($urandom); width = 2'($urandom);
                end
            end
        end
        if (!finished) chk("burst_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int nb, ne, nd, fh, rises;
        rst_n = 1'b0; trig_in = 1'b0; count = '0; width = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("reset_pulse_out", pulse_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_remaining", remaining, 0);
        chk("reset_state", state, 0);
        cmp_en = 1'b1;
        idle_cycles(3);

        // count=3 width=1: 3 pulses of 2/2, busy 12, first high after E2.
        burst(3, 1, 0, 0, nb, ne, nd, fh);
        chk("b31_busy", nb, 12);
        chk("b31_edges", ne, 3);
        chk("b31_done", nd, 1);
        chk("b31_first_high", fh, 2);
        idle_cycles(4);

        burst(1, 0, 0, 0, nb, ne, nd, fh);
        chk("b10_busy", nb, 2);
        chk("b10_edges", ne, 1);
        chk("b10_done", nd, 1);
        chk("b10_first_high", fh, 2);
        idle_cycles(4);

        burst(0, 2, 0, 0, nb, ne, nd, fh);
        chk("b0_busy", nb, 0);
        chk("b0_edges", ne, 0);
        chk("b0_done", nd, 1);
        idle_cycles(4);

        // Extra trigger edge and input changes mid-burst must not alter it.
        burst(7, 3, 0, 1, nb, ne, nd, fh);
        chk("b73_busy", nb, 56);
        chk("b73_edges", ne, 7);
        chk("b73_done", nd, 1);
        trig_in = 1'b0;
        idle_cycles(12);
        chk("b73_no_rerun_state", state, 0);

        // Reset during the second high phase.
        count = 3'd3; width = 2'd1; trig_in = 1'b1;
        rises = 0;
        begin
            bit prev = 0;
            for (int i = 0; i < 40 && rises < 2; i++) begin
                @(posedge clk); #1;
                if (pulse_out && !prev) rises++;
                prev = pulse_out;
                #1;
                trig_in = 1'b0;
            end
        end
        chk("rst_mid_reached_2nd_high", rises, 2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pulse_out", pulse_out, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_remaining", remaining, 0);
        chk("rst_mid_state", state, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle_cycles(6);
        chk("rst_mid_stays_idle", state, 0);

        // trig_in held high across reset release: exactly one burst.
        rst_n = 1'b0; trig_in = 1'b1; count = 3'd2; width = 2'd0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        burst(2, 0, 1, 0, nb, ne, nd, fh);
        chk("held_busy", nb, 4);
        chk("held_edges", ne, 2);
        chk("held_done", nd, 1);
        nb = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy) nb++;
        end
        chk("held_no_retrigger", nb, 0);
        #1 trig_in = 1'b0;
        idle_cycles(4);

        // Randomized traffic including occasional resets.
        repeat (3000) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 5) == 0) trig_in = ~trig_in;
            count = 3'($urandom);
            width = 2'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1; trig_in = 1'b0;
        idle_cycles(80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
